// File: rtl/div_rem_unit.sv
// div_rem_unit: iterative radix-2 restoring divider for the RV32IM EX stage.
// Handles DIV/DIVU/REM/REMU with RISC-V M-extension semantics, including
// divide-by-zero and signed overflow, through a start/busy/done handshake.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       request, sampled only while idle
//   alu_opcode  5'b01100 DIV, 5'b01101 DIVU, 5'b01110 REM, 5'b01111 REMU
//   operand_a   dividend (rs1)
//   operand_b   divisor (rs2)
//   flush       abort any in-flight operation (branch/jump squash)
//   busy        operation in progress (pipeline stall)
//   done        one-cycle pulse, result valid
//   result      quotient or remainder, held until the next done
//
// Optional feature: define DIV_EARLY_OUT_EN to complete in one cycle when
// |B| > |A| (quotient 0, remainder A).
module div_rem_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  alu_opcode,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned REM_W = XLEN + 1;

  localparam logic [XLEN-1:0]  INT_MIN   = 32'h8000_0000;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [REM_W-1:0]  rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   div_q;
  logic              op_rem_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  // Request decode: the four divide opcodes share the prefix 3'b011.
  logic            op_valid;
  logic            op_signed;
  logic            op_rem;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            is_div_zero;
  logic            is_overflow;

  assign op_valid    = (alu_opcode[4:2] == 3'b011);
  assign op_signed   = ~alu_opcode[0];
  assign op_rem      = alu_opcode[1];
  // |INT_MIN| wraps to 32'h80000000, which is correct read as unsigned.
  assign a_abs       = (op_signed && operand_a[XLEN-1]) ? XLEN'(XLEN'(0) - operand_a) : operand_a;
  assign b_abs       = (op_signed && operand_b[XLEN-1]) ? XLEN'(XLEN'(0) - operand_b) : operand_b;
  assign is_div_zero = (operand_b == '0);
  assign is_overflow = op_signed && (operand_a == INT_MIN) && (operand_b == '1);

  // One restoring step: shift {rem, quo} left and trial-subtract |B|.
  // Computed one bit wider than the shifted remainder so bit 33 is a true sign.
  logic [REM_W:0]  shifted;
  logic [REM_W:0]  trial;
  logic            trial_ok;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign trial    = shifted - {2'b00, div_q};
  assign trial_ok = ~trial[REM_W];

  // Sign fix-up of the unsigned magnitudes for the final result.
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;

  assign quo_fin = neg_quo_q ? XLEN'(XLEN'(0) - quo_q) : quo_q;
  assign rem_fin = neg_rem_q ? XLEN'(XLEN'(0) - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && op_valid) begin
              if (is_div_zero) begin
                result <= op_rem ? operand_a : '1;
                done   <= 1'b1;
              end else if (is_overflow) begin
                result <= op_rem ? '0 : INT_MIN;
                done   <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
              end else if (b_abs > a_abs) begin
                result <= op_rem ? operand_a : '0;
                done   <= 1'b1;
`endif
              end else begin
                rem_q     <= '0;
                quo_q     <= a_abs;
                div_q     <= b_abs;
                op_rem_q  <= op_rem;
                neg_quo_q <= op_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                neg_rem_q <= op_signed && operand_a[XLEN-1];
                cnt       <= LAST_ITER;
                busy      <= 1'b1;
                state     <= S_CALC;
              end
            end
          end

          S_CALC: begin
            if (trial_ok) begin
              rem_q <= trial[REM_W-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= shifted[REM_W-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            if (cnt == '0) begin
              state <= S_FINISH;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end

          S_FINISH: begin
            result <= op_rem_q ? rem_fin : quo_fin;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_rem_unit.sv
// tb_div_rem_unit: self-checking bench for div_rem_unit. Directed vector
// table, hand-written handshake sequences (flush, reset, start while busy,
// illegal opcode) and randomized operations against an arithmetic model.
module tb_div_rem_unit;

  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_DIVU = 5'b01101;
  localparam logic [4:0] OP_REM  = 5'b01110;
  localparam logic [4:0] OP_REMU = 5'b01111;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 0;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  alu_opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  div_rem_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alu_opcode (alu_opcode),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: M-extension semantics from plain signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit is_signed = (op == OP_DIV) || (op == OP_REM);
    bit is_rem    = (op == OP_REM) || (op == OP_REMU);
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'h0 : 32'h8000_0000;
    if (is_signed) begin
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? a % b : a / b;
  endfunction

  // Expected edges after the start edge until done is visible.
  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit     is_signed = (op == OP_DIV) || (op == OP_REM);
    longint ma, mb;
    if (b == 0) return 0;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    ma = is_signed ? longint'($signed(a)) : longint'({32'h0, a});
    mb = is_signed ? longint'($signed(b)) : longint'({32'h0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (mb > ma) return EARLY_LAT;
    return 33;
  endfunction

  // Issue one request and wait (bounded) for done.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cycles);
    start      = 1'b1;
    alu_opcode = op;
    operand_a  = a;
    operand_b  = b;
    @(posedge clk);
    #1;
    start       = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  // Watch for any done over a number of cycles.
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] res, prev, ea;
    int          lat, bc, nd;
    logic [4:0]  op;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[5]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          0};
    vecs[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          0};
    vecs[8]  = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          EARLY_LAT};
    vecs[9]  = '{OP_REMU, 32'd3,          32'd10,         32'd3,          EARLY_LAT};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[11] = '{OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33};
    vecs[12] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[13] = '{OP_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EARLY_LAT};
    vecs[14] = '{OP_DIVU, 32'h8000_0000,  32'h8000_0000,  32'd1,          33};
    vecs[15] = '{OP_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  0};

    reset_n    = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    alu_opcode = '0;
    operand_a  = '0;
    operand_b  = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    do_reset();

    // Directed vectors: result, latency, busy duration, single done pulse.
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Flush 10 cycles into DIVU 1000/3: no done, result held.
    prev       = result;
    start      = 1'b1;
    alu_opcode = OP_DIVU;
    operand_a  = 32'd1000;
    operand_b  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    count_done(40, nd);
    check("flush_no_done", 32'(nd), 32'd0);
    check("flush_result_held", result, prev);
    run_op(OP_DIVU, 32'd9, 32'd3, res, lat, bc);
    check("after_flush_result", res, 32'd3);
    check("after_flush_latency", 32'(lat), 32'd33);

    // Flush together with start in idle drops the request.
    @(posedge clk);
    #1;
    start      = 1'b1;
    flush      = 1'b1;
    alu_opcode = OP_DIV;
    operand_a  = 32'd5;
    operand_b  = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy", 32'(busy), 32'd0);
    count_done(5, nd);
    check("start_flush_no_done", 32'(nd), 32'd0);

    // Illegal opcode is ignored.
    start      = 1'b1;
    alu_opcode = 5'b00000;
    operand_a  = 32'd5;
    operand_b  = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("bad_op_busy", 32'(busy), 32'd0);
    count_done(5, nd);
    check("bad_op_no_done", 32'(nd), 32'd0);

    // Second start while busy is ignored.
    start      = 1'b1;
    alu_opcode = OP_DIVU;
    operand_a  = 32'd100;
    operand_b  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    repeat (5) @(posedge clk);
    #1;
    lat        = 5;
    start      = 1'b1;
    alu_opcode = OP_REMU;
    operand_a  = 32'd50;
    operand_b  = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat++;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_start_result", result, 32'd14);
    check("busy_start_latency", 32'(lat), 32'd33);
    count_done(40, nd);
    check("busy_start_single_done", 32'(nd), 32'd0);

    // Asynchronous reset in the middle of a calculation.
    start      = 1'b1;
    alu_opcode = OP_DIVU;
    operand_a  = 32'd1000;
    operand_b  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_result", result, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    count_done(40, nd);
    check("after_reset_no_done", 32'(nd), 32'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_DIV;
        1: op = OP_DIVU;
        2: op = OP_REM;
        default: op = OP_REMU;
      endcase
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 20);
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(op, ra, rb, res, lat, bc);
      ea = ref_result(op, ra, rb);
      check($sformatf("rand%0d_op%b_%h_%h_result", i, op, ra, rb), res, ea);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, ra, rb)));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
